button_debouncer: RTL and testbench
===================================

# button_debouncer

Multi-channel push-button conditioner sitting directly upstream of the single-pulse stage. Each raw board button is synchronised into the `clk` domain, filtered for contact bounce by a per-channel stability counter, and presented as a clean debounced level plus registered one-cycle rise/fall strobes. The debounced level feeds the single-pulse stage; the strobes are available for logic that wants press/release events directly.

## Interface
Parameters:
- `N_BUTTONS`, 5, number of independent button channels.
- `STABLE_CYCLES`, 1_000_000, consecutive identical synchronised samples required to accept a new level.
  - Minimum legal value is 2; elaboration fails below that.
  - 1_000_000 is 10 ms at 100 MHz.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `btn_raw`  input  N_BUTTONS  asynchronous, active-high raw button inputs.
- `btn_level`  output  N_BUTTONS  debounced level, registered.
- `btn_rise`  output  N_BUTTONS  one-cycle strobe when the debounced level goes 0→1.
- `btn_fall`  output  N_BUTTONS  one-cycle strobe when the debounced level goes 1→0.

## Operation
- Channels are fully independent and contain identical logic. There is no cross-channel interaction.
- Synchroniser: a 2-FF chain per channel, `btn_raw` → `s1` → `s2`. The FSM and counter look only at `s2`.
- Per-channel FSM states:
  - `LOW_STABLE`: `btn_level` = 0. If `s2` = 1, go to `RISE_CHECK` with `cnt` = 1. Otherwise stay, with `cnt` = 0.
  - `RISE_CHECK`: if `s2` = 0 (bounce), go back to `LOW_STABLE` with `cnt` = 0. If `s2` = 1 and `cnt` = STABLE_CYCLES−1, go to `HIGH_STABLE`, set `btn_level` = 1, pulse `btn_rise`, and clear `cnt`. Otherwise increment `cnt`.
  - `HIGH_STABLE`: the mirror of `LOW_STABLE`. If `s2` = 0, go to `FALL_CHECK` with `cnt` = 1.
  - `FALL_CHECK`: the mirror of `RISE_CHECK`. On success, go to `LOW_STABLE`, set `btn_level` = 0, and pulse `btn_fall`.
- Counter:
  - Width is `$clog2(STABLE_CYCLES)`, unsigned.
  - It never wraps, because it is cleared at or before STABLE_CYCLES−1.
  - Any single-sample glitch during a CHECK state restarts the qualification from zero.
- Strobes:
  - Registered, and high for exactly one cycle.
  - `btn_rise` and `btn_fall` are never both high on the same channel.
  - Back-to-back edges on one channel are at least STABLE_CYCLES cycles apart.
- Reset (`rst_n` = 0 at a rising edge):
  - `s1`, `s2`, `cnt` and all outputs go to 0; every FSM goes to `LOW_STABLE`.
  - Reset has priority over every transition, including mid-CHECK, which abandons the qualification.
  - A button held through reset release is qualified normally and produces one `btn_rise` after the full latency.

## Timing
- Press latency: raw input goes high and is stable before edge k.
  - `s1` = 1 after edge k; `s2` = 1 after edge k+1.
  - The FSM samples `s2` = 1 at edges k+2 … k+1+STABLE_CYCLES.
  - `btn_level` and `btn_rise` are high after edge k+1+STABLE_CYCLES; `btn_rise` drops after the next edge.
- Release latency: identical, using `btn_fall`.
- Pulse too short: a raw pulse lasting P ≤ STABLE_CYCLES−1 full cycles produces no output change.
- Output registers: all outputs are direct flop outputs, with no combinational path from `btn_raw`.

## Structure
- Shared package `debounce_pkg` holds:
  - the FSM state enum `db_state_t` (`LOW_STABLE`, `RISE_CHECK`, `HIGH_STABLE`, `FALL_CHECK`), 2-bit encoding;
  - the default `STABLE_CYCLES` constant, plus a small simulation constant `SIM_STABLE_CYCLES` = 4.
- Sub-module `debounce_channel` contains one synchroniser, counter and FSM. It has parameter `STABLE_CYCLES` and scalar ports.
- `button_debouncer` is a generate loop instantiating N_BUTTONS copies of `debounce_channel`.

## Test plan
All scenarios use STABLE_CYCLES = 4 and N_BUTTONS = 5.
- Clean press: `btn_raw[0]` goes 0→1 before edge 10 and is held → `btn_level[0]` = 1 and `btn_rise[0]` = 1 after edge 15; `btn_rise[0]` = 0 after edge 16; the other channels stay 0.
- Bounce: `btn_raw[1]` pattern 1,1,0,1,1,1,1 (one value per cycle, starting at edge 20) → no `btn_rise[1]` before the final run of 4 stable `s2` samples; exactly one `btn_rise[1]`, 4 edges after the glitch sample reaches `s2`.
- Short glitch: `btn_raw[2]` high for 3 cycles → `btn_level[2]`, `btn_rise[2]` and `btn_fall[2]` stay 0 throughout.
- Release: from a stable high, drop `btn_raw[0]` before edge k → `btn_fall[0]` = 1 after edge k+5 for one cycle, and `btn_level[0]` = 0.
- Reset mid-check: assert `rst_n` = 0 for one edge while `btn_raw[3]` is in `RISE_CHECK` with `cnt` = 2 → all outputs 0. The button is still held, so `btn_rise[3]` fires 5 edges after reset release.
- Simultaneous channels: `btn_raw[4:0]` = 5'b10101 all at once → `btn_rise` = 5'b10101 for exactly one cycle, at the same edge.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
package debounce_pkg;

   typedef enum logic [1:0] {
      LOW_STABLE  = 2'd0,
      RISE_CHECK  = 2'd1,
      HIGH_STABLE = 2'd2,
      FALL_CHECK  = 2'd3
   } db_state_t;

   // 10 ms at 100 MHz
   localparam int STABLE_CYCLES     = 1_000_000;
   localparam int SIM_STABLE_CYCLES = 4;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, stability counter and level FSM.
//   state       | meaning
//   LOW_STABLE  | level 0 accepted, waiting for s2 = 1
//   RISE_CHECK  | s2 = 1 seen, counting consecutive high samples
//   HIGH_STABLE | level 1 accepted, waiting for s2 = 0
//   FALL_CHECK  | s2 = 0 seen, counting consecutive low samples
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = debounce_pkg::STABLE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall
);

   if (STABLE_CYCLES < 2) begin : g_bad_param
      $error("debounce_channel: STABLE_CYCLES must be at least 2");
   end

   localparam int CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   localparam logic [1:0] ST_LOW  = LOW_STABLE;
   localparam logic [1:0] ST_RISE = RISE_CHECK;
   localparam logic [1:0] ST_HIGH = HIGH_STABLE;
   localparam logic [1:0] ST_FALL = FALL_CHECK;

   logic          s1;
   logic          s2;
   logic [1:0]    state;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         state     <= ST_LOW;
         cnt       <= '0;
         btn_level <= 1'b0;
         btn_rise  <= 1'b0;
         btn_fall  <= 1'b0;
      end else begin
         s1       <= btn_raw;
         s2       <= s1;
         btn_rise <= 1'b0;
         btn_fall <= 1'b0;
         case (state)
            ST_LOW: begin
               if (s2) begin
                  state <= ST_RISE;
                  cnt   <= CW'(1);
               end else begin
                  cnt   <= '0;
               end
            end
            ST_RISE: begin
               if (!s2) begin
                  state <= ST_LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state     <= ST_HIGH;
                  btn_level <= 1'b1;
                  btn_rise  <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_HIGH: begin
               if (!s2) begin
                  state <= ST_FALL;
                  cnt   <= CW'(1);
               end else begin
                  cnt   <= '0;
               end
            end
            default: begin
               if (s2) begin
                  state <= ST_HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state     <= ST_LOW;
                  btn_level <= 1'b0;
                  btn_fall  <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button conditioner: independent debounced level plus
// rise/fall strobes for each raw button input.
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int N_BUTTONS     = 5,
   parameter int STABLE_CYCLES = debounce_pkg::STABLE_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_BUTTONS-1:0] btn_raw,
   output logic [N_BUTTONS-1:0] btn_level,
   output logic [N_BUTTONS-1:0] btn_rise,
   output logic [N_BUTTONS-1:0] btn_fall
);

   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
      debounce_channel #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .btn_raw  (btn_raw[i]),
         .btn_level(btn_level[i]),
         .btn_rise (btn_rise[i]),
         .btn_fall (btn_fall[i])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with 5 channels and a 4-sample window.
module tb_button_debouncer;
   import debounce_pkg::*;

   localparam int NB = 5;

   logic          clk;
   logic          rst_n;
   logic [NB-1:0] btn_raw;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_rise;
   logic [NB-1:0] btn_fall;

   int edge_cnt = 0;
   int n_vec    = 0;
   int n_err    = 0;

   button_debouncer #(
      .N_BUTTONS    (NB),
      .STABLE_CYCLES(SIM_STABLE_CYCLES)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_raw),
      .btn_level(btn_level),
      .btn_rise (btn_rise),
      .btn_fall (btn_fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @edge %0d: got %0h, want %0h", tag, edge_cnt, obs, exp);
      end
   endtask

   // edge_cnt = number of rising edges seen; sampling sits 1 ns after the edge
   task automatic wait_edge(input int k);
      while (edge_cnt < k) begin
         @(posedge clk);
         edge_cnt++;
         #1;
      end
   endtask

   logic pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   initial begin
      rst_n   = 1'b0;
      btn_raw = '0;
      wait_edge(2);
      check("rst_level", 32'(btn_level), 32'h0);
      check("rst_rise",  32'(btn_rise),  32'h0);
      check("rst_fall",  32'(btn_fall),  32'h0);
      wait_edge(3);
      rst_n = 1'b1;

      // clean press on channel 0, raw high before edge 10
      wait_edge(9);
      btn_raw[0] = 1'b1;
      wait_edge(14);
      check("press_early_level", 32'(btn_level), 32'h0);
      check("press_early_rise",  32'(btn_rise),  32'h0);
      wait_edge(15);
      check("press_level", 32'(btn_level), 32'h01);
      check("press_rise",  32'(btn_rise),  32'h01);
      check("press_fall",  32'(btn_fall),  32'h0);
      wait_edge(16);
      check("press_rise_drop", 32'(btn_rise),  32'h0);
      check("press_hold",      32'(btn_level), 32'h01);

      // bounce on channel 1: pattern values present before edges 20..26
      wait_edge(19);
      btn_raw[1] = pat[0];
      for (int e = 20; e <= 30; e++) begin
         wait_edge(e);
         check("bounce_rise", 32'(btn_rise[1]), 32'(e == 28));
         if (e - 19 < 7) btn_raw[1] = pat[e-19];
      end
      check("bounce_level", 32'(btn_level), 32'h03);

      // 3-cycle glitch on channel 2 (high before edges 35, 36, 37)
      wait_edge(34);
      btn_raw[2] = 1'b1;
      wait_edge(37);
      btn_raw[2] = 1'b0;
      for (int e = 35; e <= 45; e++) begin
         wait_edge(e);
         check("glitch_ch2", {29'd0, btn_level[2], btn_rise[2], btn_fall[2]}, 32'h0);
      end

      // release channel 0 before edge 50
      wait_edge(49);
      btn_raw[0] = 1'b0;
      wait_edge(54);
      check("rel_early_fall",  32'(btn_fall),  32'h0);
      check("rel_early_level", 32'(btn_level), 32'h03);
      wait_edge(55);
      check("rel_fall",  32'(btn_fall),  32'h01);
      check("rel_level", 32'(btn_level), 32'h02);
      check("rel_rise",  32'(btn_rise),  32'h0);
      wait_edge(56);
      check("rel_fall_drop", 32'(btn_fall), 32'h0);

      // reset while channel 3 sits in RISE_CHECK with cnt = 2
      wait_edge(59);
      btn_raw[3] = 1'b1;
      wait_edge(63);
      rst_n = 1'b0;
      wait_edge(64);
      rst_n = 1'b1;
      check("midrst_level", 32'(btn_level), 32'h0);
      check("midrst_rise",  32'(btn_rise),  32'h0);
      check("midrst_fall",  32'(btn_fall),  32'h0);
      wait_edge(69);
      check("postrst_early", 32'(btn_rise), 32'h0);
      wait_edge(70);
      check("postrst_rise",  32'(btn_rise),  32'h0A);
      check("postrst_level", 32'(btn_level), 32'h0A);
      wait_edge(71);
      check("postrst_drop",  32'(btn_rise),  32'h0);

      // release everything, then press 10101 simultaneously
      wait_edge(72);
      btn_raw = '0;
      wait_edge(78);
      check("allrel_fall",  32'(btn_fall),  32'h0A);
      check("allrel_level", 32'(btn_level), 32'h0);
      wait_edge(85);
      btn_raw = 5'b10101;
      wait_edge(90);
      check("simul_early", 32'(btn_rise), 32'h0);
      wait_edge(91);
      check("simul_rise",  32'(btn_rise),  32'h15);
      check("simul_level", 32'(btn_level), 32'h15);
      check("simul_fall",  32'(btn_fall),  32'h0);
      wait_edge(92);
      check("simul_drop",  32'(btn_rise),  32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
